// File: rtl/hal_accum_core.sv
// hal_accum_core
//   Multicycle accumulator processor (FETCH/EXEC, 2 cycles per instruction)
//   with a shared instruction/data memory, an 8-entry register file, a
//   run-time load port usable while idle or halted, and a saturating
//   retired-instruction counter.
// Ports
//   clock      : system clock, rising edge
//   reset_n    : asynchronous active-low reset
//   start      : run request (honoured in IDLE or HALTED only)
//   load_en    : load-port write strobe (honoured in IDLE or HALTED only)
//   load_reg   : 0 = write memory, 1 = write register file
//   load_addr  : load target (register index uses the low 3 bits)
//   load_data  : load value
//   pc, acc    : program counter, accumulator
//   busy       : high in FETCH/EXEC
//   halted     : high in HALTED
//   retired    : instructions completed since last start, saturating
// Requires DATA_W >= 16 and ADDR_W >= 3.
module hal_accum_core #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 3,
    parameter int CNT_W  = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic              load_en,
    input  logic              load_reg,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    output logic [ADDR_W-1:0] pc,
    output logic [DATA_W-1:0] acc,
    output logic              busy,
    output logic              halted,
    output logic [CNT_W-1:0]  retired
);

    localparam int DEPTH = 2 ** ADDR_W;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_EXEC  = 2'd2;
    localparam logic [1:0] S_HALT  = 2'd3;

    localparam logic [2:0] OP_JMPI = 3'b000;
    localparam logic [2:0] OP_JREL = 3'b001;
    localparam logic [2:0] OP_LDA  = 3'b010;
    localparam logic [2:0] OP_STA  = 3'b011;
    localparam logic [2:0] OP_SUB  = 3'b100;
    localparam logic [2:0] OP_JZ   = 3'b101;
    localparam logic [2:0] OP_ADDR = 3'b110;
    localparam logic [2:0] OP_HLT  = 3'b111;

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [DATA_W-1:0] r_acc;
    logic [15:0]       r_ir;
    logic [CNT_W-1:0]  r_ret;
    logic [DATA_W-1:0] r_rf  [8];
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic              w_ctrl_idle;
    logic              w_load_ok;
    logic              w_sta;
    logic [2:0]        w_op;
    logic [ADDR_W-1:0] w_a;
    logic [DATA_W-1:0] w_opnd;
    logic [ADDR_W-1:0] w_pc_inc;
    logic [ADDR_W-1:0] w_pc_next;
    logic              w_unused_ir;

    assign w_ctrl_idle = (r_state == S_IDLE) || (r_state == S_HALT);
    assign w_load_ok   = w_ctrl_idle && load_en;
    assign w_op        = r_ir[15:13];
    assign w_a         = r_ir[ADDR_W-1:0];
    assign w_opnd      = r_mem[w_a];
    assign w_pc_inc    = r_pc + 1'b1;
    assign w_sta       = (r_state == S_EXEC) && (w_op == OP_STA);
    // Operand bits above the address field are architecturally ignored.
    assign w_unused_ir = ^r_ir;

    always_comb begin
        w_pc_next = w_pc_inc;
        case (w_op)
            OP_JMPI: w_pc_next = w_opnd[ADDR_W-1:0];
            OP_JREL: w_pc_next = r_pc + w_opnd[ADDR_W-1:0];
            OP_JZ:   w_pc_next = (r_acc == '0) ? w_a : w_pc_inc;
            OP_HLT:  w_pc_next = r_pc;
            default: w_pc_next = w_pc_inc;
        endcase
    end

    // Memory has no reset. Writes are suppressed while reset_n is low so an
    // STA caught by reset mid-instruction never lands. STA and the load
    // port are exclusive by state.
    always_ff @(posedge clock) begin
        if (reset_n) begin
            if (w_sta)
                r_mem[w_a] <= r_acc;
            else if (w_load_ok && !load_reg)
                r_mem[load_addr] <= load_data;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_pc    <= '0;
            r_acc   <= '0;
            r_ir    <= '0;
            r_ret   <= '0;
            for (int i = 0; i < 8; i++) r_rf[i] <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_HALT: begin
                    if (w_load_ok && load_reg)
                        r_rf[load_addr[2:0]] <= load_data;
                    if (start) begin
                        r_state <= S_FETCH;
                        r_pc    <= '0;
                        r_ret   <= '0;
                    end
                end
                S_FETCH: begin
                    r_ir    <= r_mem[r_pc][15:0];
                    r_state <= S_EXEC;
                end
                default: begin
                    r_pc <= w_pc_next;
                    if (r_ret != {CNT_W{1'b1}})
                        r_ret <= r_ret + 1'b1;
                    case (w_op)
                        OP_LDA:  r_acc <= w_opnd;
                        OP_SUB:  r_acc <= r_acc - w_opnd;
                        OP_ADDR: r_acc <= r_rf[r_ir[12:10]] + r_rf[r_ir[2:0]];
                        default: r_acc <= r_acc;
                    endcase
                    r_state <= (w_op == OP_HLT) ? S_HALT : S_FETCH;
                end
            endcase
        end
    end

    assign pc      = r_pc;
    assign acc     = r_acc;
    assign retired = r_ret;
    assign busy    = (r_state == S_FETCH) || (r_state == S_EXEC);
    assign halted  = (r_state == S_HALT);

endmodule

// File: tb/tb_hal_accum_core.sv
// Testbench for hal_accum_core: directed programs plus random programs,
// checked instruction-by-instruction against an ISA-level reference model.
// A small counter width is used so retired-count saturation is reachable.
module tb_hal_accum_core;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 3;
    localparam int CNT_W  = 3;
    localparam int DEPTH  = 8;
    localparam int RMAX   = (1 << CNT_W) - 1;

    logic              clock = 1'b0;
    logic              reset_n;
    logic              start;
    logic              load_en;
    logic              load_reg;
    logic [ADDR_W-1:0] load_addr;
    logic [DATA_W-1:0] load_data;
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] acc;
    logic              busy;
    logic              halted;
    logic [CNT_W-1:0]  retired;

    hal_accum_core #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clock(clock), .reset_n(reset_n), .start(start), .load_en(load_en),
        .load_reg(load_reg), .load_addr(load_addr), .load_data(load_data),
        .pc(pc), .acc(acc), .busy(busy), .halted(halted), .retired(retired)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    // Reference model state (instruction-level view)
    logic [31:0] m_mem [DEPTH];
    logic [31:0] m_r   [8];
    logic [31:0] m_acc;
    int          m_pc;
    int          m_ret;
    bit          m_halt;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic lm(input int a, input logic [31:0] d);
        @(negedge clock);
        load_en = 1'b1; load_reg = 1'b0; load_addr = a[ADDR_W-1:0]; load_data = d;
        @(posedge clock); #1;
        load_en = 1'b0;
        m_mem[a] = d;
    endtask

    task automatic lr(input int a, input logic [31:0] d);
        @(negedge clock);
        load_en = 1'b1; load_reg = 1'b1; load_addr = a[ADDR_W-1:0]; load_data = d;
        @(posedge clock); #1;
        load_en = 1'b0;
        m_r[a] = d;
    endtask

    // One instruction of the ISA, straight from the opcode table.
    task automatic model_step();
        logic [15:0] ins;
        int          a;
        ins = m_mem[m_pc][15:0];
        a   = int'(ins) % DEPTH;
        case (ins[15:13])
            3'd0: m_pc = int'(m_mem[a] % DEPTH);
            3'd1: m_pc = int'((m_pc + m_mem[a]) % DEPTH);
            3'd2: begin m_acc = m_mem[a]; m_pc = (m_pc + 1) % DEPTH; end
            3'd3: begin m_mem[a] = m_acc; m_pc = (m_pc + 1) % DEPTH; end
            3'd4: begin m_acc = m_acc - m_mem[a]; m_pc = (m_pc + 1) % DEPTH; end
            3'd5: m_pc = (m_acc == 0) ? a : (m_pc + 1) % DEPTH;
            3'd6: begin m_acc = m_r[ins[12:10]] + m_r[ins[2:0]]; m_pc = (m_pc + 1) % DEPTH; end
            default: m_halt = 1'b1;
        endcase
        if (m_ret < RMAX) m_ret++;
    endtask

    // Start a run and compare after every instruction. maxi bounds the run.
    // poke drives the load port during the second instruction, which the
    // core must ignore.
    task automatic run(input int maxi, input bit poke);
        m_pc = 0; m_ret = 0; m_halt = 1'b0;
        @(negedge clock);
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        chk("start_pc", 64'(pc), 64'(m_pc));
        chk("start_ret", 64'(retired), 64'(m_ret));
        chk("start_acc", 64'(acc), 64'(m_acc));
        chk("start_busy", 64'(busy), 64'd1);
        for (int i = 0; i < maxi && !m_halt; i++) begin
            if (poke && i == 1) begin
                load_en = 1'b1; load_reg = 1'b0; load_addr = 3'd5; load_data = 32'd999;
            end
            @(posedge clock); #1;
            load_en = 1'b0;
            @(posedge clock); #1;
            model_step();
            chk("pc", 64'(pc), 64'(m_pc));
            chk("acc", 64'(acc), 64'(m_acc));
            chk("retired", 64'(retired), 64'(m_ret));
            chk("halted", 64'(halted), 64'(m_halt));
            chk("busy", 64'(busy), 64'(!m_halt));
        end
    endtask

    // Reset asserted during EXEC; outputs must clear with no clock edge.
    task automatic mid_reset();
        @(posedge clock); #2;
        reset_n = 1'b0;
        #1;
        chk("rst_pc", 64'(pc), 64'd0);
        chk("rst_acc", 64'(acc), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_halted", 64'(halted), 64'd0);
        chk("rst_retired", 64'(retired), 64'd0);
        @(posedge clock); #1;
        @(negedge clock);
        reset_n = 1'b1;
        m_acc = '0; m_pc = 0; m_ret = 0; m_halt = 1'b0;
        for (int i = 0; i < 8; i++) m_r[i] = '0;
    endtask

    initial begin
        logic [31:0] w;
        reset_n = 1'b0; start = 1'b0; load_en = 1'b0; load_reg = 1'b0;
        load_addr = '0; load_data = '0;
        m_acc = '0; m_pc = 0; m_ret = 0; m_halt = 1'b0;
        for (int i = 0; i < 8; i++) begin m_r[i] = '0; m_mem[i] = '0; end
        #12;
        chk("init_pc", 64'(pc), 64'd0);
        chk("init_acc", 64'(acc), 64'd0);
        chk("init_busy", 64'(busy), 64'd0);
        chk("init_halted", 64'(halted), 64'd0);
        chk("init_retired", 64'(retired), 64'd0);
        @(negedge clock);
        reset_n = 1'b1;

        // Subtract-and-store program
        lm(0, 32'h4005); lm(1, 32'h8006); lm(2, 32'h6007); lm(3, 32'hE000);
        lm(4, 32'd0); lm(5, 32'd10); lm(6, 32'd3); lm(7, 32'd0);
        run(10, 1'b0);
        chk("t2_acc", 64'(acc), 64'd7);
        chk("t2_ret", 64'(retired), 64'd4);
        chk("t2_pc", 64'(pc), 64'd3);
        chk("t2_halted", 64'(halted), 64'd1);
        chk("t2_mem7", 64'(dut.r_mem[7]), 64'd7);

        // Restart from HALTED with a load attempt while busy
        run(10, 1'b1);
        chk("t6_mem5", 64'(dut.r_mem[5]), 64'd10);
        chk("t6_acc", 64'(acc), 64'd7);

        // JZ taken, then not taken
        lm(0, 32'h4004); lm(1, 32'hA006); lm(2, 32'hE000); lm(4, 32'd0); lm(6, 32'hE000);
        run(10, 1'b0);
        chk("t3_pc_taken", 64'(pc), 64'd6);
        lm(4, 32'd1);
        run(10, 1'b0);
        chk("t3_pc_nt", 64'(pc), 64'd2);

        // Register add with wrap
        lr(1, 32'hFFFF_FFFF); lr(2, 32'd2);
        lm(0, 32'hC402); lm(1, 32'hE000);
        run(10, 1'b0);
        chk("t4_acc", 64'(acc), 64'd1);

        // JREL wraps 3+7 -> 2
        lm(0, 32'h0005); lm(5, 32'd3); lm(3, 32'h2004); lm(4, 32'd7); lm(2, 32'hE000);
        run(10, 1'b0);
        chk("t5_jrel_pc", 64'(pc), 64'd2);

        // Fall-through from address 7 wraps to 0; endless loop cut by reset
        lm(0, 32'h0001); lm(1, 32'd7); lm(7, 32'h4000);
        run(5, 1'b0);
        mid_reset();

        // Random programs, each ended by a mid-instruction reset
        for (int t = 0; t < 8; t++) begin
            for (int i = 0; i < 8; i++) begin
                w = $urandom();
                lm(i, w);
            end
            for (int i = 0; i < 8; i++) begin
                w = $urandom();
                lr(i, w);
            end
            run(12, 1'b0);
            mid_reset();
        end

        for (int i = 0; i < 8; i++) chk("final_mem", 64'(dut.r_mem[i]), 64'(m_mem[i]));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
